// File: rtl/i2c_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sram_pkg
// Description : Shared sizes and FSM state codes for the I2C slave with SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_sram_pkg;

    localparam int DEV_ADDR_W = 7;
    localparam int MEM_ADDR_W = 8;
    localparam int DATA_W     = 8;
    localparam int MEM_DEPTH  = 256;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DEV_ADDR = 4'd1,
        ST_DEV_ACK  = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_ACK  = 4'd4,
        ST_WR_DATA  = 4'd5,
        ST_WR_ACK   = 4'd6,
        ST_RD_DATA  = 4'd7,
        ST_RD_ACK   = 4'd8,
        ST_IGNORE   = 4'd9
    } state_t;

endpackage : i2c_sram_pkg
`default_nettype wire

// File: rtl/i2c_sram_embedded_sram.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sram_embedded_sram
// Description : 256x8 single-port SRAM, synchronous write, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_sram_embedded_sram
    import i2c_sram_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [MEM_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Contents are deliberately not reset; only the port is clocked.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end else if (re) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule : i2c_sram_embedded_sram
`default_nettype wire

// File: rtl/i2c_sram_embedded.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sram_embedded
// Description : I2C slave with programmable device address and 256x8 SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_sram_embedded
    import i2c_sram_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    inout  wire                   sda,
    input  logic                  scl,
    input  logic [DEV_ADDR_W-1:0] my_addr,
    output logic [DATA_W-1:0]     curr_data,
    output logic [DEV_ADDR_W-1:0] rcvd_device_address,
    output logic [32:0]           state,
    output logic                  rcvd_mode
);

    logic                  r_scl_s1, r_scl_s2, r_scl_prev;
    logic                  r_sda_s1, r_sda_s2, r_sda_prev;
    state_t                r_state;
    logic [2:0]            r_bit_cnt;
    logic [DATA_W-1:0]     r_shift;
    logic [MEM_ADDR_W-1:0] r_ptr;
    logic                  r_sda_oe;
    logic [DATA_W-1:0]     r_curr_data;
    logic [DEV_ADDR_W-1:0] r_dev_addr;
    logic                  r_mode;
    logic                  r_addr_match;

    logic                  w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [DATA_W-1:0]     w_shift_in;
    logic                  w_we, w_re;
    logic [DATA_W-1:0]     w_rdata;

    assign w_scl_rise = r_scl_s2 & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_s2 & r_scl_prev;
    assign w_start    = r_scl_s2 & r_scl_prev & r_sda_prev & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_prev & ~r_sda_prev & r_sda_s2;
    assign w_shift_in = {r_shift[DATA_W-2:0], r_sda_s2};

    assign w_we = (r_state == ST_WR_DATA) && w_scl_rise && (r_bit_cnt == 3'd7)
                  && !w_start && !w_stop;
    // The array is read continuously at the pointer so a byte is ready well
    // before the SCL fall that starts shifting it out.
    assign w_re = !w_we;

    i2c_sram_embedded_sram u_sram (
        .clk   (clk),
        .we    (w_we),
        .re    (w_re),
        .addr  (r_ptr),
        .wdata (w_shift_in),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_s1     <= 1'b1;
            r_scl_s2     <= 1'b1;
            r_scl_prev   <= 1'b1;
            r_sda_s1     <= 1'b1;
            r_sda_s2     <= 1'b1;
            r_sda_prev   <= 1'b1;
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= '0;
            r_ptr        <= '0;
            r_sda_oe     <= 1'b0;
            r_curr_data  <= '0;
            r_dev_addr   <= '0;
            r_mode       <= 1'b0;
            r_addr_match <= 1'b0;
        end else begin
            r_scl_s1   <= scl;
            r_scl_s2   <= r_scl_s1;
            r_scl_prev <= r_scl_s2;
            r_sda_s1   <= sda;
            r_sda_s2   <= r_sda_s1;
            r_sda_prev <= r_sda_s2;

            if (w_start) begin
                r_state   <= ST_DEV_ADDR;
                r_bit_cnt <= 3'd0;
                r_sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
            end else begin
                case (r_state)
                    ST_DEV_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_shift_in;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd6) begin
                                r_addr_match <= (w_shift_in[DEV_ADDR_W-1:0] == my_addr);
                            end
                            if (r_bit_cnt == 3'd7) begin
                                r_dev_addr <= r_shift[DEV_ADDR_W-1:0];
                                r_mode     <= r_sda_s2;
                                r_state    <= r_addr_match ? ST_DEV_ACK : ST_IGNORE;
                            end
                        end
                    end
                    // First fall in an ACK state pulls SDA low, the next one
                    // ends the ninth clock.
                    ST_DEV_ACK, ST_MEM_ACK, ST_WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                if (r_state == ST_DEV_ACK) begin
                                    r_state <= ST_MEM_ADDR;
                                end else if (r_state == ST_WR_ACK) begin
                                    r_ptr   <= r_ptr + 1'b1;
                                    r_state <= ST_WR_DATA;
                                end else if (r_mode) begin
                                    r_shift     <= w_rdata;
                                    r_curr_data <= w_rdata;
                                    r_sda_oe    <= ~w_rdata[DATA_W-1];
                                    r_state     <= ST_RD_DATA;
                                end else begin
                                    r_state <= ST_WR_DATA;
                                end
                            end
                        end
                    end
                    ST_MEM_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_shift_in;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_ptr   <= w_shift_in;
                                r_state <= ST_MEM_ACK;
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_shift_in;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_curr_data <= w_shift_in;
                                r_state     <= ST_WR_ACK;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 3'd7) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_RD_ACK;
                            end else begin
                                r_sda_oe  <= ~r_shift[DATA_W-2];
                                r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (r_sda_s2) begin
                                r_state <= ST_IGNORE;
                            end else begin
                                r_ptr <= r_ptr + 1'b1;
                            end
                        end else if (w_scl_fall) begin
                            r_shift     <= w_rdata;
                            r_curr_data <= w_rdata;
                            r_sda_oe    <= ~w_rdata[DATA_W-1];
                            r_bit_cnt   <= 3'd0;
                            r_state     <= ST_RD_DATA;
                        end
                    end
                    default: begin
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda                 = r_sda_oe ? 1'b0 : 1'bz;
    assign curr_data           = r_curr_data;
    assign rcvd_device_address = r_dev_addr;
    assign rcvd_mode           = r_mode;
    assign state               = {29'd0, r_state};

endmodule : i2c_sram_embedded
`default_nettype wire

// File: tb/tb_i2c_sram_embedded.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_sram_embedded
// Description : Bit-banged I2C master with memory model and read scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_sram_embedded;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scl = 1'b1;
    logic        m_low = 1'b0;
    logic [6:0]  my_addr = 7'h3C;
    logic [7:0]  curr_data;
    logic [6:0]  rcvd_device_address;
    logic [32:0] state;
    logic        rcvd_mode;
    wire         sda;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_sram_embedded dut (
        .clk                 (clk),
        .reset               (reset),
        .sda                 (sda),
        .scl                 (scl),
        .my_addr             (my_addr),
        .curr_data           (curr_data),
        .rcvd_device_address (rcvd_device_address),
        .state               (state),
        .rcvd_mode           (rcvd_mode)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mem_model [256];
    logic [7:0] exp_q [$];

    task automatic check_val(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Works both from idle and as a repeated START from SCL low.
    task automatic bus_start();
        m_low = 1'b0; wait_clk(4);
        scl = 1'b1;   wait_clk(8);
        m_low = 1'b1; wait_clk(8);
        scl = 1'b0;   wait_clk(4);
    endtask

    task automatic bus_stop();
        m_low = 1'b1; wait_clk(4);
        scl = 1'b1;   wait_clk(8);
        m_low = 1'b0; wait_clk(8);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_low = ~b[i]; wait_clk(4);
            scl = 1'b1;    wait_clk(8);
            scl = 1'b0;    wait_clk(4);
        end
        m_low = 1'b0; wait_clk(4);
        scl = 1'b1;   wait_clk(4);
        ack = (sda === 1'b0);
        wait_clk(4);
        scl = 1'b0;   wait_clk(4);
    endtask

    task automatic rd_byte(input logic nack);
        logic [7:0] b;
        for (int i = 7; i >= 0; i--) begin
            m_low = 1'b0; wait_clk(4);
            scl = 1'b1;   wait_clk(4);
            b[i] = (sda === 1'b1);
            wait_clk(4);
            scl = 1'b0;   wait_clk(4);
        end
        m_low = ~nack; wait_clk(4);
        scl = 1'b1;    wait_clk(8);
        scl = 1'b0;    wait_clk(4);
        if (exp_q.size() == 0) check_val("sb_empty", {25'd0, b}, 33'h1_0000_0000);
        else                   check_val("rd_data", {25'd0, b}, {25'd0, exp_q.pop_front()});
    endtask

    task automatic write_txn(input logic [7:0] addr, input logic [7:0] d0, input logic [7:0] d1);
        logic ack;
        bus_start();
        send_byte({7'h3C, 1'b0}, ack); check_val("wr_dev_ack", {32'd0, ack}, 33'd1);
        send_byte(addr, ack);          check_val("wr_mem_ack", {32'd0, ack}, 33'd1);
        send_byte(d0, ack);            check_val("wr_d0_ack", {32'd0, ack}, 33'd1);
        mem_model[addr] = d0;
        send_byte(d1, ack);            check_val("wr_d1_ack", {32'd0, ack}, 33'd1);
        mem_model[8'(addr + 8'd1)] = d1;
        bus_stop();
    endtask

    task automatic read_txn(input logic [7:0] addr, input int nbytes);
        logic ack;
        bus_start();
        send_byte({7'h3C, 1'b1}, ack); check_val("rd_dev_ack", {32'd0, ack}, 33'd1);
        send_byte(addr, ack);          check_val("rd_mem_ack", {32'd0, ack}, 33'd1);
        for (int i = 0; i < nbytes; i++) begin
            exp_q.push_back(mem_model[8'(addr + 8'(i))]);
            rd_byte(i == nbytes - 1);
        end
        bus_stop();
    endtask

    initial begin
        logic ack;
        wait_clk(5);
        check_val("rst_state", state, 33'd0);
        check_val("rst_curr_data", {25'd0, curr_data}, 33'd0);
        check_val("rst_dev_addr", {26'd0, rcvd_device_address}, 33'd0);
        check_val("rst_mode", {32'd0, rcvd_mode}, 33'd0);
        check_val("rst_sda", {32'd0, sda}, 33'd1);
        reset = 1'b0;
        wait_clk(10);

        // Basic write then read-back of two bytes.
        write_txn(8'h7C, 8'hA5, 8'h5A);
        check_val("wr_mode", {32'd0, rcvd_mode}, 33'd0);
        check_val("wr_curr_data", {25'd0, curr_data}, 33'h5A);
        check_val("wr_state_idle", state, 33'd0);
        read_txn(8'h7C, 2);
        check_val("rd_dev_addr", {26'd0, rcvd_device_address}, 33'h3C);
        check_val("rd_mode", {32'd0, rcvd_mode}, 33'd1);
        check_val("rd_state_idle", state, 33'd0);

        // Foreign device address: no ACK, ignored, memory untouched.
        bus_start();
        send_byte({7'h3D, 1'b0}, ack);
        check_val("bad_dev_nack", {32'd0, ack}, 33'd0);
        check_val("bad_dev_state", state, 33'd9);
        check_val("bad_dev_addr", {26'd0, rcvd_device_address}, 33'h3D);
        send_byte(8'h7C, ack);
        send_byte(8'hEE, ack);
        check_val("bad_dev_data_nack", {32'd0, ack}, 33'd0);
        bus_stop();
        read_txn(8'h7C, 1);

        // Pointer wrap from 0xFF to 0x00 on both write and read.
        write_txn(8'hFF, 8'h11, 8'h22);
        read_txn(8'hFF, 2);

        // Reset while slave drives bit 7 (=0) of the byte at 0x00.
        bus_start();
        send_byte({7'h3C, 1'b1}, ack);
        send_byte(8'h00, ack);
        check_val("rd_drive_low", {32'd0, sda}, 33'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_mid_sda", {32'd0, sda}, 33'd1);
        check_val("rst_mid_state", state, 33'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_clk(4);
        bus_stop();
        read_txn(8'h7C, 1);

        // Repeated START after the memory-address ACK.
        bus_start();
        send_byte({7'h3C, 1'b0}, ack); check_val("rs_dev_ack", {32'd0, ack}, 33'd1);
        send_byte(8'h10, ack);         check_val("rs_mem_ack", {32'd0, ack}, 33'd1);
        bus_start();
        check_val("rs_state", state, 33'd1);
        send_byte({7'h3C, 1'b1}, ack); check_val("rs_dev2_ack", {32'd0, ack}, 33'd1);
        check_val("rs_mode", {32'd0, rcvd_mode}, 33'd1);
        send_byte(8'h7C, ack);         check_val("rs_mem2_ack", {32'd0, ack}, 33'd1);
        exp_q.push_back(mem_model[8'h7C]);
        rd_byte(1'b1);
        bus_stop();
        check_val("rs_state_idle", state, 33'd0);
        check_val("sb_drained", {1'b0, 32'(exp_q.size())}, 33'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_i2c_sram_embedded
`default_nettype wire
